// File: rtl/demo_txn_sequencer_if.sv
// ---------------------------------------------------------------------------
// demo_txn_sequencer_if
//
// Purpose : Request/response channel between the push-button transaction
//           sequencer and the bus master that executes its transactions.
//
// Signals :
//   m_req    sequencer -> master  transaction request, held until m_ack
//   m_write  sequencer -> master  1 = write, 0 = read
//   m_slave  sequencer -> master  target slave (1, 2 or 3 = bus bridge)
//   m_addr   sequencer -> master  slave-local address
//   m_wdata  sequencer -> master  write data
//   m_ack    master -> sequencer  request accepted
//   m_done   master -> sequencer  one-cycle completion pulse
//   m_rdata  master -> sequencer  read data, valid with m_done
//
// Modports:
//   master : the requesting side (the sequencer)
//   slave  : the executing side (the bus master that serves the request)
// ---------------------------------------------------------------------------
interface demo_txn_sequencer_if;
  logic        m_req;
  logic        m_write;
  logic [1:0]  m_slave;
  logic [11:0] m_addr;
  logic [7:0]  m_wdata;
  logic        m_ack;
  logic        m_done;
  logic [7:0]  m_rdata;

  modport master (
    output m_req,
    output m_write,
    output m_slave,
    output m_addr,
    output m_wdata,
    input  m_ack,
    input  m_done,
    input  m_rdata
  );

  modport slave (
    input  m_req,
    input  m_write,
    input  m_slave,
    input  m_addr,
    input  m_wdata,
    output m_ack,
    output m_done,
    output m_rdata
  );
endinterface

// File: rtl/demo_txn_sequencer.sv
// ---------------------------------------------------------------------------
// demo_txn_sequencer
//
// Purpose : Turns a debounced push-button press into one bus transaction.
//           The switches select the operation: sw[3:2] = 00/01/10 writes
//           {6'b0, sw[1:0]} to slave 1/2/3, sw[3:2] = 11 reads from the
//           slave that was last written successfully. The result (write data
//           or read data) is shown on the LEDs; a transaction that does not
//           finish within TIMEOUT_CYCLES parks the block in ERR with
//           led = 8'hEE until the next press.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles before a key level is accepted
//   TIMEOUT_CYCLES   maximum cycles from request assertion to m_done
//   DEMO_ADDR        fixed slave-local address used by every transaction
//
// Ports:
//   clk         system clock, all logic on its rising edge
//   rst         synchronous, active-high reset
//   key_exec_n  raw asynchronous push-button, active low
//   sw          sw[3:2] mode, sw[1:0] write data
//   bus         request channel to the bus master (master modport)
//   led         result display
//   busy        high while a transaction is in flight (REQ or WAIT)
//   err         high in ERR (last transaction timed out)
// ---------------------------------------------------------------------------
module demo_txn_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 50,
  parameter int unsigned TIMEOUT_CYCLES  = 4096,
  parameter logic [11:0] DEMO_ADDR       = 12'h000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        key_exec_n,
  input  logic [3:0]                  sw,
  demo_txn_sequencer_if.master        bus,
  output logic [7:0]                  led,
  output logic                        busy,
  output logic                        err
);

  // -------------------------------------------------------------------------
  // Local types and constants
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Debounce counter runs 0 .. DEBOUNCE_CYCLES-1; the level flips on the
  // cycle the counter would reach DEBOUNCE_CYCLES.
  localparam int unsigned DB_W =
    (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // Timeout counter is cleared on entry to REQ and reads TIMEOUT_CYCLES-1
  // during the last permitted cycle of REQ/WAIT.
  localparam int unsigned TO_W =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] LED_TIMEOUT = 8'hEE;

  // -------------------------------------------------------------------------
  // Registers and wires
  // -------------------------------------------------------------------------
  logic            r_key_meta;
  logic            r_key_sync;
  logic            r_key_db;
  logic            r_key_db_d;
  logic [DB_W-1:0] r_db_cnt;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_write;
  logic [1:0]      r_slave;
  logic [7:0]      r_wdata;
  logic [1:0]      r_last_slave;
  logic [7:0]      r_led;
  logic [TO_W-1:0] r_to_cnt;

  logic            w_press;
  logic            w_busy;
  logic            w_to_hit;
  logic            w_start;
  logic            w_complete;
  logic            w_timeout;

  logic            w_dec_write;
  logic [1:0]      w_dec_slave;
  logic [7:0]      w_dec_wdata;

  // -------------------------------------------------------------------------
  // Key synchronizer
  // Idle level of the button is 1, so the chain resets to 1 to avoid a
  // spurious press right after reset.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every flop samples the
  // values from before the edge; with = the chain would collapse into one
  // flop and the result would depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_meta <= 1'b1;
      r_key_sync <= 1'b1;
    end else begin
      r_key_meta <= key_exec_n;
      r_key_sync <= r_key_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Debouncer
  // The accepted level follows the synchronized level only after the two
  // have disagreed for DEBOUNCE_CYCLES consecutive cycles. Any cycle where
  // they agree again (a bounce) clears the count.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_db   <= 1'b1;
      r_key_db_d <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_key_db_d <= r_key_db;
      if (r_key_sync == r_key_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == DB_LAST) begin
        r_key_db <= r_key_sync;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + 1'b1;
      end
    end
  end

  // One-cycle pulse on an accepted 1->0 transition; releases are ignored.
  assign w_press = r_key_db_d & ~r_key_db;

  // -------------------------------------------------------------------------
  // Switch decode, sampled only in the press-event cycle
  // -------------------------------------------------------------------------
  // NOTE: every signal driven by a combinational block gets a default at the
  // top, so no branch can leave it unassigned and infer a latch.
  always_comb begin
    w_dec_write = 1'b1;
    w_dec_slave = 2'd1;
    w_dec_wdata = {6'b0, sw[1:0]};
    case (sw[3:2])
      2'b00: w_dec_slave = 2'd1;
      2'b01: w_dec_slave = 2'd2;
      2'b10: w_dec_slave = 2'd3;
      2'b11: begin
        w_dec_write = 1'b0;
        w_dec_slave = r_last_slave;
        w_dec_wdata = 8'h00;
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Transaction FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_to_hit = (r_to_cnt == TO_LAST);

  // -------------------------------------------------------------------------
  // Transaction FSM: next state and event strobes
  // Completion has priority over the timeout when both land in the same
  // cycle: the master did finish in time. An ack arriving on the deadline
  // cycle without done is too late and still times out.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE, S_ERR: begin
        // A press while busy never reaches this branch, so it is dropped.
        if (w_press) begin
          w_start     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.m_ack && bus.m_done) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ERR;
        end else if (bus.m_ack) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.m_done) begin
          w_complete  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_to_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_ERR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_busy = (r_state == S_REQ) || (r_state == S_WAIT);

  // -------------------------------------------------------------------------
  // Transaction datapath
  // Mode, slave and data are latched at the press so later switch movement
  // cannot disturb a transaction in flight. last_slave only moves on a
  // completed write; reads and timed-out writes leave it alone.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_write      <= 1'b0;
      r_slave      <= 2'd1;
      r_wdata      <= 8'h00;
      r_last_slave <= 2'd1;
      r_led        <= 8'h00;
      r_to_cnt     <= '0;
    end else begin
      if (w_start) begin
        r_write  <= w_dec_write;
        r_slave  <= w_dec_slave;
        r_wdata  <= w_dec_wdata;
        r_to_cnt <= '0;
      end else if (w_busy && !w_to_hit) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_complete) begin
        r_led <= r_write ? r_wdata : bus.m_rdata;
        if (r_write) begin
          r_last_slave <= r_slave;
        end
      end else if (w_timeout) begin
        r_led <= LED_TIMEOUT;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // m_req is decoded from the state so it rises the cycle after the press,
  // and drops on the same edge as an ack, a timeout or a reset.
  // -------------------------------------------------------------------------
  assign bus.m_req   = (r_state == S_REQ);
  assign bus.m_write = r_write;
  assign bus.m_slave = r_slave;
  assign bus.m_addr  = DEMO_ADDR;
  assign bus.m_wdata = r_wdata;

  assign led  = r_led;
  assign busy = w_busy;
  assign err  = (r_state == S_ERR);

  // Request qualifiers must not move while a request is pending.
  a_req_fields_stable: assert property (
    @(posedge clk) disable iff (rst)
      (bus.m_req && $past(bus.m_req)) |->
        $stable({bus.m_write, bus.m_slave, bus.m_wdata})
  );

endmodule

// File: tb/tb_demo_txn_sequencer.sv
// ---------------------------------------------------------------------------
// tb_demo_txn_sequencer
//
// Directed bench for demo_txn_sequencer. A small bus-master model answers
// requests with a programmable ack and done latency, records the fields of
// each request and flags protocol slips; the main sequence drives the key
// and switches and compares the results against hand-computed values.
// ---------------------------------------------------------------------------
module tb_demo_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_exec_n;
  logic [3:0] sw;
  logic [7:0] led;
  logic       busy;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  demo_txn_sequencer_if bus ();

  demo_txn_sequencer #(
    .DEBOUNCE_CYCLES (50),
    .TIMEOUT_CYCLES  (4096),
    .DEMO_ADDR       (12'h000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_exec_n (key_exec_n),
    .sw         (sw),
    .bus        (bus),
    .led        (led),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Bus-master model state
  // -------------------------------------------------------------------------
  int          ack_delay  = 3;
  int          done_delay = 20;
  bit          done_en    = 1'b1;
  int          phase      = 0;   // 0 idle, 1 request seen, 2 acked
  int          mcnt       = 0;
  int          req_count  = 0;
  int          early_drop = 0;
  int          late_drop  = 0;
  int          unstable   = 0;
  int          busy_cnt   = 0;
  bit          ack_sent   = 1'b0;
  logic        cap_write;
  logic [1:0]  cap_slave;
  logic [11:0] cap_addr;
  logic [7:0]  cap_wdata;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin : master_model
    bus.m_ack  = 1'b0;
    bus.m_done = 1'b0;
    forever begin
      @(negedge clk);
      if (ack_sent) begin
        if (bus.m_req) late_drop++;
        ack_sent = 1'b0;
      end
      bus.m_ack  = 1'b0;
      bus.m_done = 1'b0;
      if (busy) busy_cnt++;
      if (err && phase != 0) phase = 0;

      if (phase == 0 && bus.m_req) begin
        phase     = 1;
        mcnt      = 0;
        req_count++;
        cap_write = bus.m_write;
        cap_slave = bus.m_slave;
        cap_addr  = bus.m_addr;
        cap_wdata = bus.m_wdata;
      end else if (phase == 1 && !bus.m_req) begin
        early_drop++;
        phase = 0;
      end

      if (phase == 1) begin
        if ({bus.m_write, bus.m_slave, bus.m_addr, bus.m_wdata} !==
            {cap_write, cap_slave, cap_addr, cap_wdata}) unstable++;
        if (mcnt >= ack_delay) begin
          bus.m_ack = 1'b1;
          ack_sent  = 1'b1;
          mcnt      = 0;
          if (done_delay == 0) begin
            bus.m_done = 1'b1;
            phase      = 0;
          end else begin
            phase = 2;
          end
        end else begin
          mcnt++;
        end
      end else if (phase == 2) begin
        mcnt++;
        if (done_en && mcnt >= done_delay) begin
          bus.m_done = 1'b1;
          phase      = 0;
        end
      end
    end
  end

  // Hold the key low for 'hold' cycles (optionally moving the switches at
  // cycle 'sw_at'), then release and let the debouncer settle high.
  task automatic press(input int hold, input int sw_at, input logic [3:0] sw_new);
    key_exec_n = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == sw_at) sw = sw_new;
    end
    key_exec_n = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin : main_seq
    int base;
    int n;

    rst         = 1'b1;
    key_exec_n  = 1'b1;
    sw          = 4'b0000;
    bus.m_rdata = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    check("rst_m_req",   bus.m_req,   0);
    check("rst_m_write", bus.m_write, 0);
    check("rst_m_slave", bus.m_slave, 1);
    check("rst_m_addr",  bus.m_addr,  12'h000);
    check("rst_m_wdata", bus.m_wdata, 0);
    check("rst_led",     led,         0);
    check("rst_busy",    busy,        0);
    check("rst_err",     err,         0);

    // Write slave 1, data 1; switches move mid-transaction and must not matter
    sw = 4'b0001;
    base = req_count;
    press(100, 54, 4'b0010);
    wait_idle("t1_idle");
    check("t1_reqs",  req_count - base, 1);
    check("t1_write", cap_write, 1);
    check("t1_slave", cap_slave, 1);
    check("t1_addr",  cap_addr,  12'h000);
    check("t1_wdata", cap_wdata, 8'h01);
    check("t1_led",   led,       8'h01);

    // Write slave 2, then read back from the last written slave
    sw = 4'b0110;
    press(100, -1, 4'b0000);
    wait_idle("t2w_idle");
    check("t2w_slave", cap_slave, 2);
    check("t2w_led",   led,       8'h02);
    sw = 4'b1100;
    bus.m_rdata = 8'h02;
    press(100, -1, 4'b0000);
    wait_idle("t2r_idle");
    check("t2r_write", cap_write, 0);
    check("t2r_slave", cap_slave, 2);
    check("t2r_led",   led,       8'h02);
    // A read must not change last_slave and must show m_rdata, not sw data
    sw = 4'b1111;
    bus.m_rdata = 8'hA5;
    press(100, -1, 4'b0000);
    wait_idle("t2r2_idle");
    check("t2r2_slave", cap_slave, 2);
    check("t2r2_led",   led,       8'hA5);

    // Ack and done in the same cycle: completion straight from REQ
    sw = 4'b1001;
    done_delay = 0;
    press(100, -1, 4'b0000);
    wait_idle("t3_idle");
    check("t3_slave", cap_slave, 3);
    check("t3_led",   led,       8'h01);
    check("t3_m_req", bus.m_req, 0);
    done_delay = 20;

    // Bouncing key: only the final stable low produces a transaction
    sw = 4'b0010;
    base = req_count;
    for (int s = 0; s < 20; s++) begin
      key_exec_n = (s % 2 == 1) ? 1'b1 : 1'b0;
      repeat (10) @(negedge clk);
    end
    check("t4_no_req_bounce", req_count - base, 0);
    press(100, -1, 4'b0000);
    wait_idle("t4_idle");
    check("t4_reqs",  req_count - base, 1);
    check("t4_slave", cap_slave, 1);
    check("t4_led",   led,       8'h02);

    // Timeout: master acks but never completes
    sw = 4'b0100;
    done_en = 1'b0;
    busy_cnt = 0;
    press(100, -1, 4'b0000);
    n = 0;
    while (!err && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("t5_err",      err,       1);
    check("t5_led",      led,       8'hEE);
    check("t5_busy",     busy,      0);
    check("t5_m_req",    bus.m_req, 0);
    check("t5_busy_len", busy_cnt,  4096);
    // Recovery from ERR with a normal write
    done_en = 1'b1;
    sw = 4'b0011;
    press(100, -1, 4'b0000);
    wait_idle("t5r_idle");
    check("t5r_err",   err,       0);
    check("t5r_slave", cap_slave, 1);
    check("t5r_wdata", cap_wdata, 8'h03);
    check("t5r_led",   led,       8'h03);

    // Second press during WAIT is discarded
    sw = 4'b0101;
    done_delay = 200;
    base = req_count;
    press(60, -1, 4'b0000);
    check("t6_busy_wait", busy, 1);
    press(60, -1, 4'b0000);
    wait_idle("t6_idle");
    repeat (10) @(negedge clk);
    check("t6_reqs",  req_count - base, 1);
    check("t6_busy",  busy,      0);
    check("t6_led",   led,       8'h01);

    // Make last_slave = 3 so a reset back to 1 is observable
    done_delay = 20;
    sw = 4'b1011;
    press(100, -1, 4'b0000);
    wait_idle("t7w_idle");
    check("t7w_led", led, 8'h03);

    // Reset during WAIT abandons the transaction; the late done is ignored
    done_delay = 200;
    sw = 4'b1001;
    base = req_count;
    press(60, -1, 4'b0000);
    check("t7_busy_before", busy,      1);
    check("t7_req_before",  bus.m_req, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_m_req",   bus.m_req,   0);
    check("t7_led",     led,         0);
    check("t7_busy",    busy,        0);
    check("t7_err",     err,         0);
    check("t7_m_slave", bus.m_slave, 1);
    n = 0;
    while (phase != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("t7_model_done", phase,            0);
    check("t7_led_after",  led,              0);
    check("t7_busy_after", busy,             0);
    check("t7_reqs",       req_count - base, 1);
    done_delay = 20;
    sw = 4'b1100;
    bus.m_rdata = 8'h77;
    press(100, -1, 4'b0000);
    wait_idle("t7r_idle");
    check("t7r_write", cap_write, 0);
    check("t7r_slave", cap_slave, 1);
    check("t7r_led",   led,       8'h77);

    // Protocol observations accumulated by the master model
    check("proto_early_drop", early_drop, 0);
    check("proto_late_drop",  late_drop,  0);
    check("proto_unstable",   unstable,   0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/demo_txn_sequencer.md
DEMO_TXN_SEQUENCER -- requirements
Module: demo_txn_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 50: consecutive stable cycles before a key level is accepted.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum cycles from request assertion to m_done.
REQ-003 The block SHALL have parameter DEMO_ADDR, default 12'h000: fixed slave-local address used by every transaction.
REQ-004 The block SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-006 The block SHALL have port key_exec_n, input, 1: raw asynchronous push-button, active low.
REQ-007 The block SHALL have port sw, input, 4: sw[3:2] mode, sw[1:0] write data.
REQ-008 The block SHALL have port m_req, output, 1: transaction request to bus master.
REQ-009 The block SHALL have port m_write, output, 1: 1 = write, 0 = read.
REQ-010 The block SHALL have port m_slave, output, 2: target slave (1, 2 or 3 = bus bridge).
REQ-011 The block SHALL have port m_addr, output, 12: slave-local address.
REQ-012 The block SHALL have port m_wdata, output, 8: write data.
REQ-013 The block SHALL have port m_ack, input, 1: master accepted the request.
REQ-014 The block SHALL have port m_done, input, 1: one-cycle completion pulse.
REQ-015 The block SHALL have port m_rdata, input, 8: read data, valid with m_done.
REQ-016 The block SHALL have port led, output, 8: result display.
REQ-017 The block SHALL have port busy, output, 1: high in any state other than IDLE and ERR.
REQ-018 The block SHALL have port err, output, 1: high in ERR.

Function
REQ-019 key_exec_n SHALL pass a 2-flop synchronizer; the debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-020 A press event SHALL be a one-cycle pulse on a debounced 1->0 transition; releases generate nothing.
REQ-021 States SHALL be IDLE, REQ, WAIT, ERR.
REQ-022 Decode on a press event in IDLE or ERR: sw[3:2]=00 -> write slave 1; 01 -> write slave 2; 10 -> write slave 3; 11 -> read from last_slave.
REQ-023 Write data SHALL be {6'b0, sw[1:0]}, captured with mode and slave in the press-event cycle; later sw changes have no effect on that transaction.
REQ-024 last_slave SHALL update to the written slave on completion of a write only; reset value 1.
REQ-025 The state SHALL move to REQ on the cycle after the press event, and m_req SHALL assert in that cycle; m_write/m_slave/m_addr/m_wdata SHALL be stable while m_req is high.
REQ-026 In REQ, m_req SHALL stay high until a cycle with m_ack=1, then drop and the state SHALL move to WAIT.
REQ-027 m_done in WAIT SHALL return the state to IDLE; led SHALL be set to m_wdata for a write or m_rdata for a read.
REQ-028 m_ack and m_done together in REQ SHALL be treated as completion and go directly to IDLE.
REQ-029 m_done outside WAIT/REQ SHALL be ignored.
REQ-030 The timeout counter SHALL clear on entering REQ and count through REQ and WAIT; reaching TIMEOUT_CYCLES SHALL force ERR, drop m_req, set led=8'hEE, and leave last_slave unchanged.
REQ-031 Press events while busy SHALL be discarded, not queued.
REQ-032 ERR SHALL be left only by a press event, which starts a new transaction per REQ-022.

Reset
REQ-033 rst SHALL force: state IDLE, m_req=0, m_write=0, m_slave=1, m_addr=DEMO_ADDR, m_wdata=0, led=0, busy=0, err=0, last_slave=1, debounced level=1, counters=0.
REQ-034 rst asserted mid-transaction SHALL drop m_req at that edge and abandon the transaction; a subsequent m_done SHALL be ignored.

Verification
REQ-035 sw=4'b0001, 100-cycle press, master acks after 3 and done after 20 -> m_req high until ack, m_write=1, m_slave=1, m_wdata=8'h01, led=8'h01.
REQ-036 Write slave 2 with sw=4'b0110, then sw=4'b1100 press with m_rdata=8'h02 -> read issued to m_slave=2, led=8'h02.
REQ-037 Key bouncing 0/1 every 10 cycles for 200 cycles, then stable low -> exactly one transaction.
REQ-038 Master never asserts m_done -> ERR after TIMEOUT_CYCLES, err=1, led=8'hEE; next press with sw=4'b0011 -> normal write, err=0, led=8'h03.
REQ-039 Second press during WAIT, plus rst asserted in WAIT of a later transaction -> no extra request; after rst, led=0, m_req=0, subsequent read targets slave 1.
